// File: rtl/spram_arbiter_if.sv
// Request/response and RAM-side bundle for the two-port SPRAM arbiter.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface spram_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  ram_en;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  ram_rd_data,
    output gnt0, gnt1, rvalid0, rvalid1,
    output rdata0, rdata1,
    output ram_en, ram_wr_en, ram_addr, ram_wr_data
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output ram_rd_data,
    input  gnt0, gnt1, rvalid0, rvalid1,
    input  rdata0, rdata1,
    input  ram_en, ram_wr_en, ram_addr, ram_wr_data
  );
endinterface

// File: rtl/spram_arbiter.sv
// Sticky round-robin arbiter sharing one single-port synchronous RAM
// between two requesters; read data returns one cycle later, tagged by port.
module spram_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic clk,
  input  logic rst_n,
  spram_arbiter_if.slave bus
);
  localparam int RW = $clog2(MAX_BURST + 1);
  localparam logic [RW-1:0] MB = RW'(MAX_BURST);

  logic          r_last;
  logic          r_prev_gnt;
  logic [RW-1:0] r_run;
  logic          r_rd_pend;
  logic          r_rd_port;

  logic w_both;
  logic w_keep;
  logic w_any;
  logic w_sel;
  logic w_we;

  always_comb begin
    w_both = bus.req0 & bus.req1;
    w_keep = r_prev_gnt && (r_run < MB);
    w_any  = rst_n & (bus.req0 | bus.req1);
    // Under contention the owner keeps the RAM until its burst is spent.
    if (w_both) w_sel = w_keep ? r_last : ~r_last;
    else        w_sel = bus.req1;
    w_we = w_sel ? bus.we1 : bus.we0;
  end

  assign bus.gnt0      = w_any & ~w_sel;
  assign bus.gnt1      = w_any & w_sel;
  assign bus.ram_en    = w_any;
  assign bus.ram_wr_en = w_any & w_we;

  assign bus.ram_addr =
    !w_any ? '0 : (w_sel ? bus.addr1 : bus.addr0);
  assign bus.ram_wr_data =
    !w_any ? '0 : (w_sel ? bus.wdata1 : bus.wdata0);

  assign bus.rvalid0 = r_rd_pend & ~r_rd_port;
  assign bus.rvalid1 = r_rd_pend & r_rd_port;
  assign bus.rdata0  = bus.ram_rd_data;
  assign bus.rdata1  = bus.ram_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= 1'b1;
      r_prev_gnt <= 1'b0;
      r_run      <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_port  <= 1'b0;
    end else if (w_any) begin
      if (w_sel == r_last && r_prev_gnt) begin
        if (r_run < MB) r_run <= r_run + 1'b1;
      end else begin
        r_run  <= RW'(1);
        r_last <= w_sel;
      end
      r_prev_gnt <= 1'b1;
      r_rd_pend  <= ~w_we;
      r_rd_port  <= w_sel;
    end else begin
      r_prev_gnt <= 1'b0;
      r_run      <= '0;
      r_rd_pend  <= 1'b0;
    end
  end
endmodule
